// File: rtl/mips_cpu_pkg.sv
// Shared CPU-side types and constants used by the data bus bridge.
package mips_cpu_pkg;

    typedef enum logic [1:0] {BR_IDLE, BR_BUS, BR_DONE} bridge_state_t;

    localparam logic [31:0] MIPS_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
        logic        read;
        logic        write;
    } bus_req_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & MIPS_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mips_cpu_timeout_counter.sv
// Saturating wait-cycle counter; flags expiry once TIMEOUT_CYCLES-1 cycles have been counted.
module mips_cpu_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != {CW{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mips_cpu_data_bus_bridge.sv
// Turns the CPU's level-held data strobes into single Avalon-MM transfers,
// stalls the CPU until completion and aborts hung slaves with a sticky error.
module mips_cpu_data_bus_bridge
    import mips_cpu_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_READDATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    input  logic [3:0]  cpu_byteenable,
    output logic [31:0] cpu_readdata,
    output logic        cpu_stall,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        bus_error
);
    bridge_state_t state;
    bus_req_t      req;
    logic          expired;

    mips_cpu_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (state == BR_IDLE),
        .enable (state == BR_BUS),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= BR_IDLE;
            req          <= '0;
            cpu_readdata <= '0;
            bus_error    <= 1'b0;
        end else begin
            case (state)
                BR_IDLE: begin
                    if (cpu_read ^ cpu_write) begin
                        req.address    <= align_word(cpu_address);
                        req.writedata  <= cpu_writedata;
                        req.byteenable <= cpu_byteenable;
                        req.read       <= cpu_read;
                        req.write      <= cpu_write;
                        state          <= BR_BUS;
                    end else if (cpu_read && cpu_write) begin
                        bus_error <= 1'b1;
                        state     <= BR_DONE;
                    end
                end
                BR_BUS: begin
                    // A slave answering on the expiry cycle still wins over the abort.
                    if (!avm_waitrequest) begin
                        req.read  <= 1'b0;
                        req.write <= 1'b0;
                        if (req.read) cpu_readdata <= avm_readdata;
                        state <= BR_DONE;
                    end else if (expired) begin
                        req.read  <= 1'b0;
                        req.write <= 1'b0;
                        bus_error <= 1'b1;
                        if (req.read) cpu_readdata <= ERR_READDATA;
                        state <= BR_DONE;
                    end
                end
                BR_DONE: begin
                    // The still-held strobe belongs to the finished request.
                    if (!cpu_read && !cpu_write) state <= BR_IDLE;
                end
                default: state <= BR_IDLE;
            endcase
        end
    end

    assign cpu_stall      = (state == BR_BUS) ||
                            ((state == BR_IDLE) && (cpu_read || cpu_write));
    assign avm_address    = req.address;
    assign avm_read       = req.read;
    assign avm_write      = req.write;
    assign avm_writedata  = req.writedata;
    assign avm_byteenable = req.byteenable;

endmodule
